// File: rtl/regs_port_sched_pkg.sv
// Shared sizes, state encoding and init-value helper for the register-port
// scheduler.
package regs_port_sched_pkg;

  localparam int REG_WIDTH  = 8;
  localparam int ADDR_WIDTH = 3;
  localparam int DEPTH      = 1 << ADDR_WIDTH;
  localparam int UNITY_VAL  = 8;  // 1<<3: unity after immediate scaling

  typedef logic [REG_WIDTH-1:0]  reg_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    RD1,
    RD2
  } state_t;

  function automatic reg_t init_value(addr_t a);
    return (a == '0) ? '0 : reg_t'(UNITY_VAL);
  endfunction

endpackage

// File: rtl/regs_port_sched_if.sv
// Core-side bundle: operand-pair read handshake plus the register write port.
interface regs_port_sched_if;
  import regs_port_sched_pkg::*;

  logic  req;
  addr_t addr_a;
  addr_t addr_b;
  logic  ready;
  logic  valid;
  reg_t  op_a;
  reg_t  op_b;
  logic  wr_en;
  addr_t wr_addr_in;
  reg_t  wr_data;
  logic  init_done;

  modport master (
    output req, addr_a, addr_b, wr_en, wr_addr_in, wr_data,
    input  ready, valid, op_a, op_b, init_done
  );

  modport slave (
    input  req, addr_a, addr_b, wr_en, wr_addr_in, wr_data,
    output ready, valid, op_a, op_b, init_done
  );

endinterface

// File: rtl/regs_fwd_capture.sv
// Write-forwarding capture stage: remembers whether a write hit the address
// issued to the memory, and selects forwarded data over the stale read.
module regs_fwd_capture
  import regs_port_sched_pkg::*;
(
  input  logic  clk,
  input  logic  n_reset,
  input  logic  issue,
  input  logic  wr_en,
  input  addr_t wr_addr,
  input  reg_t  wr_data,
  input  addr_t rd_addr,
  input  reg_t  mem_q,
  output reg_t  operand
);

  logic hit;
  reg_t fwd_data;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      hit      <= 1'b0;
      fwd_data <= '0;
    end else if (issue) begin
      hit      <= wr_en && (wr_addr == rd_addr);
      fwd_data <= wr_data;
    end
  end

  // The memory has no write-to-read bypass, so a same-cycle write wins here.
  assign operand = hit ? fwd_data : mem_q;

endmodule

// File: rtl/regs_port_sched.sv
// Sequencer for the 1R/1W register memory: init sweep after reset, then
// operand-pair reads (A then B) over the single read port with forwarding.
module regs_port_sched
  import regs_port_sched_pkg::*;
(
  input  logic               clk,
  input  logic               n_reset,
  regs_port_sched_if.slave   bus,
  output reg_t               mem_d,
  output addr_t              mem_rd_addr,
  output addr_t              mem_wr_addr,
  output logic               mem_we,
  input  reg_t               mem_q
);

  state_t state, state_next;
  addr_t  cnt;
  addr_t  addr_b_q;
  logic   valid_q;
  reg_t   op_a_q, op_b_q;
  logic   init_done_q;
  logic   issue;
  logic   ready;
  reg_t   captured;

  regs_fwd_capture u_fwd_capture (
    .clk     (clk),
    .n_reset (n_reset),
    .issue   (issue),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr_in),
    .wr_data (bus.wr_data),
    .rd_addr (mem_rd_addr),
    .mem_q   (mem_q),
    .operand (captured)
  );

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state       <= INIT;
      cnt         <= '0;
      addr_b_q    <= '0;
      valid_q     <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      init_done_q <= 1'b0;
    end else begin
      state   <= state_next;
      valid_q <= (state == RD2);
      if (state == INIT) begin
        cnt <= cnt + addr_t'(1);
        if (cnt == addr_t'(DEPTH - 1)) init_done_q <= 1'b1;
      end
      if (ready && bus.req) addr_b_q <= bus.addr_b;
      if (state == RD1)     op_a_q   <= captured;
      if (state == RD2)     op_b_q   <= captured;
    end
  end

  // NOTE: every always_comb output gets a default before the case so no
  // path leaves a signal unassigned and infers a latch.
  always_comb begin
    state_next  = state;
    issue       = 1'b0;
    mem_we      = bus.wr_en;
    mem_wr_addr = bus.wr_addr_in;
    mem_d       = bus.wr_data;
    mem_rd_addr = bus.addr_a;

    unique case (state)
      INIT: begin
        mem_we      = 1'b1;
        mem_wr_addr = cnt;
        mem_d       = init_value(cnt);
        if (cnt == addr_t'(DEPTH - 1)) state_next = IDLE;
      end
      IDLE: begin
        if (bus.req) begin
          issue      = 1'b1;
          state_next = RD1;
        end
      end
      RD1: begin
        mem_rd_addr = addr_b_q;
        issue       = 1'b1;
        state_next  = RD2;
      end
      RD2: begin
        mem_rd_addr = addr_b_q;
        state_next  = IDLE;
      end
      default: state_next = INIT;
    endcase

    if (!n_reset) mem_we = 1'b0;
  end

  assign ready = (state == IDLE) && n_reset;

  assign bus.ready     = ready;
  assign bus.valid     = valid_q;
  assign bus.op_a      = op_a_q;
  assign bus.op_b      = op_b_q;
  assign bus.init_done = init_done_q;

endmodule

// File: tb/tb_regs_port_sched.sv
// Directed bench for regs_port_sched with a behavioural 1R/1W register memory.
module tb_regs_port_sched;
  import regs_port_sched_pkg::*;

  logic clk = 1'b0;
  logic n_reset;
  reg_t  mem_d, mem_q;
  addr_t mem_rd_addr, mem_wr_addr;
  logic  mem_we;

  int n_asserts = 0;
  int n_fail    = 0;

  regs_port_sched_if bus ();

  regs_port_sched dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .bus         (bus),
    .mem_d       (mem_d),
    .mem_rd_addr (mem_rd_addr),
    .mem_wr_addr (mem_wr_addr),
    .mem_we      (mem_we),
    .mem_q       (mem_q)
  );

  always #5 clk = ~clk;

  // Register memory: synchronous read, old data on a same-address write.
  reg_t mem [DEPTH];
  always @(posedge clk) begin
    if (mem_we) mem[mem_wr_addr] <= mem_d;
    mem_q <= mem[mem_rd_addr];
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic write_reg(input addr_t a, input reg_t d);
    bus.wr_en      = 1'b1;
    bus.wr_addr_in = a;
    bus.wr_data    = d;
    #1;
    chk("wr_mem_we", mem_we, 1);
    cyc();
    bus.wr_en = 1'b0;
  endtask

  // Issue a pair in the current cycle; wphase 1/2/3 adds a write in the
  // issue / RD1 / RD2 cycle. Returns in the cycle where valid is high.
  task automatic read_pair(input string tag, input addr_t a, input addr_t b,
                           input reg_t ea, input reg_t eb,
                           input int wphase, input addr_t wa, input reg_t wd);
    for (int ph = 0; ph < 3; ph++) begin
      bus.req        = (ph == 0);
      bus.addr_a     = a;
      bus.addr_b     = b;
      bus.wr_en      = (wphase == ph + 1);
      bus.wr_addr_in = wa;
      bus.wr_data    = wd;
      #1;
      if (ph == 0) begin
        chk({tag, "_ready"}, bus.ready, 1);
        chk({tag, "_rd_a"}, mem_rd_addr, a);
      end else begin
        chk({tag, "_busy"}, bus.ready, 0);
        chk({tag, "_novalid"}, bus.valid, 0);
        if (ph == 1) chk({tag, "_rd_b"}, mem_rd_addr, b);
      end
      cyc();
    end
    bus.req   = 1'b0;
    bus.wr_en = 1'b0;
    #1;
    chk({tag, "_valid"}, bus.valid, 1);
    chk({tag, "_op_a"}, bus.op_a, ea);
    chk({tag, "_op_b"}, bus.op_b, eb);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    n_reset        = 1'b0;
    bus.req        = 1'b0;
    bus.addr_a     = '0;
    bus.addr_b     = '0;
    bus.wr_en      = 1'b0;
    bus.wr_addr_in = '0;
    bus.wr_data    = '0;
    repeat (3) cyc();

    // Reset state, with a write request that must not reach the memory.
    bus.wr_en = 1'b1;
    #1;
    chk("rst_mem_we", mem_we, 0);
    chk("rst_ready", bus.ready, 0);
    chk("rst_valid", bus.valid, 0);
    chk("rst_init_done", bus.init_done, 0);
    chk("rst_op_a", bus.op_a, 0);
    chk("rst_op_b", bus.op_b, 0);

    // Test 1: init sweep, with wr_en and req ignored throughout.
    n_reset        = 1'b1;
    bus.wr_addr_in = 3'd2;
    bus.wr_data    = 8'h77;
    bus.req        = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      chk("init_we", mem_we, 1);
      chk("init_addr", mem_wr_addr, i);
      chk("init_data", mem_d, (i == 0) ? 0 : 8'h08);
      chk("init_ready", bus.ready, 0);
      chk("init_done_low", bus.init_done, 0);
      cyc();
    end
    bus.req   = 1'b0;
    bus.wr_en = 1'b0;
    #1;
    chk("init_done", bus.init_done, 1);
    chk("idle_ready", bus.ready, 1);
    chk("init_wr_dropped", mem[2], 8'h08);
    chk("init_no_valid", bus.valid, 0);
    read_pair("t1", 3'd0, 3'd3, 8'h00, 8'h08, 0, 3'd0, 8'h00);

    // Test 2: plain reads after writes; operands hold after valid drops.
    write_reg(3'd2, 8'h15);
    write_reg(3'd5, 8'h2A);
    read_pair("t2", 3'd2, 3'd5, 8'h15, 8'h2A, 0, 3'd0, 8'h00);
    cyc();
    chk("t2_valid_drop", bus.valid, 0);
    chk("t2_hold_a", bus.op_a, 8'h15);
    chk("t2_hold_b", bus.op_b, 8'h2A);

    // Test 3: write to A's address in A's issue cycle is forwarded.
    read_pair("t3", 3'd4, 3'd1, 8'h33, 8'h08, 1, 3'd4, 8'h33);
    read_pair("t3_mem", 3'd4, 3'd4, 8'h33, 8'h33, 0, 3'd0, 8'h00);

    // Test 4: a=b=6; write in RD1 reaches only B, write in RD2 reaches neither.
    read_pair("t4_rd1", 3'd6, 3'd6, 8'h08, 8'h7F, 2, 3'd6, 8'h7F);
    write_reg(3'd6, 8'h08);
    read_pair("t4_rd2", 3'd6, 3'd6, 8'h08, 8'h08, 3, 3'd6, 8'h7F);
    cyc();

    // Test 5: req held high; pairs (1,2), (5,4), (6,0) back to back.
    for (int k = 0; k < 10; k++) begin
      bus.req = (k < 9);
      case (k / 3)
        0:       begin bus.addr_a = 3'd1; bus.addr_b = 3'd2; end
        1:       begin bus.addr_a = 3'd5; bus.addr_b = 3'd4; end
        default: begin bus.addr_a = 3'd6; bus.addr_b = 3'd0; end
      endcase
      #1;
      chk("t5_ready", bus.ready, (k % 3 == 0));
      chk("t5_valid", bus.valid, (k % 3 == 0) && (k > 0));
      case (k)
        3: begin chk("t5_p0_a", bus.op_a, 8'h08); chk("t5_p0_b", bus.op_b, 8'h15); end
        6: begin chk("t5_p1_a", bus.op_a, 8'h2A); chk("t5_p1_b", bus.op_b, 8'h33); end
        9: begin chk("t5_p2_a", bus.op_a, 8'h7F); chk("t5_p2_b", bus.op_b, 8'h00); end
        default: ;
      endcase
      cyc();
    end
    bus.req = 1'b0;

    // Test 6: reset during RD2 abandons the read and reruns the sweep.
    write_reg(3'd1, 8'h55);
    bus.req    = 1'b1;
    bus.addr_a = 3'd1;
    bus.addr_b = 3'd1;
    cyc();
    bus.req = 1'b0;
    cyc();
    n_reset        = 1'b0;
    bus.wr_en      = 1'b1;
    bus.wr_addr_in = 3'd3;
    bus.wr_data    = 8'hAA;
    #1;
    chk("t6_rst_we", mem_we, 0);
    chk("t6_rst_ready", bus.ready, 0);
    cyc();
    n_reset        = 1'b1;
    bus.wr_addr_in = 3'd1;
    bus.wr_data    = 8'h99;
    #1;
    chk("t6_no_valid", bus.valid, 0);
    chk("t6_init_done", bus.init_done, 0);
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      chk("t6_init_addr", mem_wr_addr, i);
      chk("t6_init_data", mem_d, (i == 0) ? 0 : 8'h08);
      chk("t6_no_valid_init", bus.valid, 0);
      cyc();
    end
    bus.wr_en = 1'b0;
    #1;
    chk("t6_ready", bus.ready, 1);
    chk("t6_r1_reinit", mem[1], 8'h08);
    chk("t6_r3_reinit", mem[3], 8'h08);
    read_pair("t6", 3'd1, 3'd3, 8'h08, 8'h08, 0, 3'd0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/regs_port_sched.md
Name: regs_port_sched

Overview:
Sequencer and port scheduler for the single-read/single-write register memory, which has 1-cycle synchronous read and no write-to-read bypass. Runs a hardware init sweep after reset: reg0=0, all others=unity. Then serves two-operand read requests (A then B) over the one read port, forwarding same-cycle writes. Sits between core control/ALU and the register memory.

Parameters:
REG_WIDTH, 8, register data width
ADDR_WIDTH, 3, register address width
DEPTH, 8, number of registers (must equal 2**ADDR_WIDTH)
UNITY_VAL, 8, init value for regs 1..DEPTH-1 (1<<3, accounts for immediate scaling)

Ports:
clk  in  1  clock
n_reset  in  1  synchronous active-low reset
req  in  1  operand-pair read request
addr_a  in  ADDR_WIDTH  operand A register address
addr_b  in  ADDR_WIDTH  operand B register address
ready  out  1  high when a req is accepted this cycle
valid  out  1  one-cycle pulse: op_a/op_b valid
op_a  out  REG_WIDTH  operand A value
op_b  out  REG_WIDTH  operand B value
wr_en  in  1  register write request from core
wr_addr_in  in  ADDR_WIDTH  write address
wr_data  in  REG_WIDTH  write data
init_done  out  1  high once the init sweep completes
mem_d  out  REG_WIDTH  to memory d
mem_rd_addr  out  ADDR_WIDTH  to memory rd_addr
mem_wr_addr  out  ADDR_WIDTH  to memory wr_addr
mem_we  out  1  to memory we
mem_q  in  REG_WIDTH  from memory q (valid one cycle after rd_addr)

Behaviour:
- Reset: on any clk edge with n_reset=0: state<=INIT, cnt<=0, valid<=0, op_a<=0, op_b<=0, init_done<=0. mem_we forced 0 combinationally while n_reset=0.
- Reset mid-operation: an in-flight read is abandoned, no valid pulse, and the init sweep reruns from reg0.
- States: INIT, IDLE, RD1, RD2.
- INIT: mem_we=1, mem_wr_addr=cnt, mem_d=(cnt==0)?0:UNITY_VAL, cnt++. At cnt==DEPTH-1 go to IDLE and set init_done<=1. Takes exactly DEPTH cycles.
- INIT: ready=0; wr_en and req are ignored (dropped, not queued).
- ready = (state==IDLE) && n_reset.
- Writes outside INIT: mem_we=wr_en, mem_wr_addr=wr_addr_in, mem_d=wr_data. Writes are always accepted, in any non-INIT state, at full rate.
- IDLE: if req, mem_rd_addr=addr_a (direct from input); latch addr_b; go to RD1. Otherwise mem_rd_addr=addr_a (don't-care).
- RD1: capture A; mem_rd_addr=latched addr_b; go to RD2.
- RD2: capture B; valid<=1 at the RD2->IDLE edge.
- valid is high for exactly one cycle, the first IDLE cycle after RD2. That cycle may accept a new req.
- Latency: req accepted in cycle N -> valid high in cycle N+3. Sustained throughput: one pair per 3 cycles.
- op_a/op_b hold their values until the next capture; they are not cleared when valid drops.
- Forwarding, per operand:
  - At each issue cycle, register hit <= wr_en && (wr_addr_in==mem_rd_addr), and register fwd_data <= wr_data.
  - At capture: operand = hit ? fwd_data : mem_q.
  - Each operand therefore reflects every write up to and including its own issue cycle.
  - Writes after an operand's issue cycle are not reflected; the core must tolerate this.
- addr_a==addr_b is legal. With a write to that address in the RD1 cycle, op_a=old value and op_b=new value.
- No special casing of reg0 after init; software keeps it zero.

Decomposition:
- Shared package/constants file: REG_WIDTH, ADDR_WIDTH, DEPTH, UNITY_VAL, and the state enum (INIT, IDLE, RD1, RD2). Reuse the existing register-size macros where present.
- One natural sub-module, regs_fwd_capture: holds the hit/fwd_data registers and the capture mux. Instantiated once; shared by A and B since their captures never coincide.
- The top-level instantiates the scheduler FSM alongside the existing register memory in the core.

Test Plan:
1. Init: release n_reset -> mem_we=1 for 8 cycles, writing addr0=0x00 and addr1..7=0x08. init_done and ready rise in cycle 9. Then req a=0, b=3 -> op_a=0x00, op_b=0x08.
2. Basic read: write r2=0x15, then r5=0x2A, then req a=2, b=5 in cycle N -> valid only in cycle N+3, op_a=0x15, op_b=0x2A.
3. Forward A: req a=4 plus wr_en addr=4 data=0x33 in the same cycle -> op_a=0x33. Same stimulus without forwarding logic would return 0x08.
4. Forward B: a=b=6 (r6=0x08). Write 0x7F to r6 in the RD1 cycle -> op_a=0x08, op_b=0x7F. Repeat with the write in the RD2 cycle -> op_b=0x08.
5. Back-to-back: req held high with changing addresses -> ready high every third cycle, valid pulses every 3 cycles, and each pair matches its own addresses.
6. Reset mid-op: n_reset=0 during RD2 after writing r1=0x55 -> no valid pulse, init sweep reruns. A later read of r1 returns 0x08. wr_en issued during INIT is ignored.
